// File: rtl/fm_decim_fir_if.sv
// rtl/fm_decim_fir_if.sv - sample, coefficient-load and output bundle for fm_decim_fir
interface fm_decim_fir_if #(
    parameter int N  = 12,
    parameter int CW = 9,
    parameter int AW = 11
);
    logic                 sync_clr;
    logic                 in_valid;
    logic signed [N-1:0]  d [2];
    logic                 coef_we;
    logic [AW-1:0]        coef_addr;
    logic signed [CW-1:0] coef_data;
    logic                 out_valid;
    logic signed [N-1:0]  q [2];

    modport master (
        output sync_clr, in_valid, d, coef_we, coef_addr, coef_data,
        input  out_valid, q
    );

    modport slave (
        input  sync_clr, in_valid, d, coef_we, coef_addr, coef_data,
        output out_valid, q
    );
endinterface

// File: rtl/fm_decim_fir.sv
// rtl/fm_decim_fir.sv - complex polyphase decimating FIR with run-time coefficient RAM
// Optional output clamping to N bits when FM_DECIM_SAT_EN is defined.
module fm_decim_fir #(
    parameter int N     = 12,
    parameter int CW    = 9,
    parameter int DECIM = 200,
    parameter int NSEG  = 6,
    parameter int ACCW  = 20,
    parameter int SHIFT = 3
) (
    input  logic          clk,
    input  logic          n_reset,
    fm_decim_fir_if.slave bus
);
    localparam int TAPS = NSEG * DECIM;
    localparam int AW   = $clog2(TAPS);
    localparam int PW   = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int PRW  = N + CW;
    localparam int CHN  = (NSEG > 1) ? NSEG - 1 : 1;
    localparam logic [PW-1:0] PH_LAST = PW'(DECIM - 1);

    logic signed [CW-1:0]   coef_mem [TAPS];
    logic [AW-1:0]          rd_addr [NSEG];

    logic [PW-1:0]          phase_q;
    logic                   s1_valid_q;
    logic [PW-1:0]          s1_phase_q;
    logic signed [N-1:0]    s1_d_q [2];
    logic signed [CW-1:0]   s1_coef_q [NSEG];
    logic                   s2_valid_q;
    logic [PW-1:0]          s2_phase_q;
    logic signed [N:0]      s2_p_q [NSEG][2];
    logic signed [ACCW-1:0] acc_q [NSEG][2];
    logic                   done_q;
    logic signed [ACCW-1:0] chain_q [CHN][2];
    logic signed [ACCW-1:0] chain_d [NSEG][2];
    logic                   out_valid_q;
    logic signed [N-1:0]    q_q [2];

    // Product rescaled back to sample units; the shift floors toward -inf.
    function automatic logic signed [N:0] mul_shift(input logic signed [CW-1:0] c,
                                                    input logic signed [N-1:0]  x);
        logic signed [PRW-1:0] full;
        full = PRW'(c) * PRW'(x);
        return (N+1)'(full >>> (CW - 1));
    endfunction

    function automatic logic signed [ACCW-1:0] sext(input logic signed [N:0] p);
        return ACCW'(p);
    endfunction

`ifdef FM_DECIM_SAT_EN
    function automatic logic signed [N-1:0] sat_n(input logic signed [ACCW-1:0] x);
        if (x[ACCW-1:N-1] == {(ACCW-N+1){x[ACCW-1]}})
            return x[N-1:0];
        return x[ACCW-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    endfunction
`endif

    // Write port has no reset: coefficients survive n_reset and sync_clr.
    always_ff @(posedge clk) begin
        if (bus.coef_we && ({1'b0, bus.coef_addr} < (AW+1)'(TAPS)))
            coef_mem[bus.coef_addr] <= bus.coef_data;
    end

    always_comb begin
        for (int s = 0; s < NSEG; s++)
            rd_addr[s] = AW'(s * DECIM + int'(phase_q));
    end

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            chain_d[0][k] = acc_q[0][k] >>> SHIFT;
            for (int s = 1; s < NSEG; s++)
                chain_d[s][k] = chain_q[s-1][k] + (acc_q[s][k] >>> SHIFT);
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            phase_q     <= PH_LAST;
            s1_valid_q  <= 1'b0;
            s1_phase_q  <= '0;
            s2_valid_q  <= 1'b0;
            s2_phase_q  <= '0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            for (int k = 0; k < 2; k++) begin
                s1_d_q[k] <= '0;
                q_q[k]    <= '0;
                for (int s = 0; s < NSEG; s++) begin
                    s2_p_q[s][k] <= '0;
                    acc_q[s][k]  <= '0;
                end
                for (int s = 0; s < CHN; s++) chain_q[s][k] <= '0;
            end
            for (int s = 0; s < NSEG; s++) s1_coef_q[s] <= '0;
        end else if (bus.sync_clr) begin
            phase_q     <= PH_LAST;
            s1_valid_q  <= 1'b0;
            s1_phase_q  <= '0;
            s2_valid_q  <= 1'b0;
            s2_phase_q  <= '0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            for (int k = 0; k < 2; k++) begin
                s1_d_q[k] <= '0;
                q_q[k]    <= '0;
                for (int s = 0; s < NSEG; s++) begin
                    s2_p_q[s][k] <= '0;
                    acc_q[s][k]  <= '0;
                end
                for (int s = 0; s < CHN; s++) chain_q[s][k] <= '0;
            end
            for (int s = 0; s < NSEG; s++) s1_coef_q[s] <= '0;
        end else begin
            s1_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                phase_q    <= (phase_q == '0) ? PH_LAST : phase_q - PW'(1);
                s1_phase_q <= phase_q;
                s1_d_q     <= bus.d;
                for (int s = 0; s < NSEG; s++) s1_coef_q[s] <= coef_mem[rd_addr[s]];
            end

            s2_valid_q <= s1_valid_q;
            s2_phase_q <= s1_phase_q;
            for (int s = 0; s < NSEG; s++)
                for (int k = 0; k < 2; k++)
                    s2_p_q[s][k] <= mul_shift(s1_coef_q[s], s1_d_q[k]);

            // The first sample of a block restarts every accumulator.
            if (s2_valid_q) begin
                for (int s = 0; s < NSEG; s++)
                    for (int k = 0; k < 2; k++)
                        acc_q[s][k] <= (s2_phase_q == PH_LAST) ? sext(s2_p_q[s][k])
                                                               : acc_q[s][k] + sext(s2_p_q[s][k]);
            end
            done_q      <= s2_valid_q && (s2_phase_q == '0);
            out_valid_q <= done_q;

            if (done_q) begin
                for (int k = 0; k < 2; k++) begin
                    for (int s = 0; s < NSEG - 1; s++) chain_q[s][k] <= chain_d[s][k];
`ifdef FM_DECIM_SAT_EN
                    q_q[k] <= sat_n(chain_d[NSEG-1][k]);
`else
                    q_q[k] <= N'(chain_d[NSEG-1][k]);
`endif
                end
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.q[0]      = q_q[0];
    assign bus.q[1]      = q_q[1];
endmodule
